// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG master.
// tap_state_t : 4-bit TAP state in the standard encoding (0 = Test_Logic_Reset).
// cmd_op_t    : command opcodes accepted on the command port.
// seq_state_t : sequencer states of jtag_master.
// *_PRE_TMS   : TMS bits leading from Run_Test_Idle into Shift, sent LSB first.
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR       = 4'd0,
    RTI       = 4'd1,
    SEL_DR    = 4'd2,
    CAP_DR    = 4'd3,
    SHIFT_DR  = 4'd4,
    EXIT1_DR  = 4'd5,
    PAUSE_DR  = 4'd6,
    EXIT2_DR  = 4'd7,
    UPDATE_DR = 4'd8,
    SEL_IR    = 4'd9,
    CAP_IR    = 4'd10,
    SHIFT_IR  = 4'd11,
    EXIT1_IR  = 4'd12,
    PAUSE_IR  = 4'd13,
    EXIT2_IR  = 4'd14,
    UPDATE_IR = 4'd15
  } tap_state_t;

  typedef enum logic [1:0] {
    OP_RESET   = 2'd0,
    OP_IDLE    = 2'd1,
    OP_IR_SCAN = 2'd2,
    OP_DR_SCAN = 2'd3
  } cmd_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_SEQ,
    S_PARK,
    S_PRE,
    S_SHIFT,
    S_POST
  } seq_state_t;

  localparam int unsigned RESET_TMS_CYCLES = 5;
  // Widest pre-shift TMS pattern: IR prefix plus the extra TLR->RTI step.
  localparam int unsigned PRE_W            = 5;
  localparam logic [2:0]  DR_PRE_TMS       = 3'b001;
  localparam logic [3:0]  IR_PRE_TMS       = 4'b0011;

endpackage

// File: rtl/jtag_tap_next.sv
// Standard 16-state TAP controller next-state function (purely combinational).
// Ports:
//   state      - current TAP state
//   tms        - TMS value sampled at the coming TCK rising edge
//   next_state - TAP state after that edge
module jtag_tap_next
  import jtag_pkg::*;
(
  input  tap_state_t state,
  input  logic       tms,
  output tap_state_t next_state
);

  always_comb begin
    next_state = TLR;
    case (state)
      TLR:       next_state = tms ? TLR       : RTI;
      RTI:       next_state = tms ? SEL_DR    : RTI;
      SEL_DR:    next_state = tms ? SEL_IR    : CAP_DR;
      CAP_DR:    next_state = tms ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:  next_state = tms ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:  next_state = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:  next_state = tms ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:  next_state = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR: next_state = tms ? SEL_DR    : RTI;
      SEL_IR:    next_state = tms ? TLR       : CAP_IR;
      CAP_IR:    next_state = tms ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:  next_state = tms ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:  next_state = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:  next_state = tms ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:  next_state = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR: next_state = tms ? SEL_DR    : RTI;
      default:   next_state = TLR;
    endcase
  end

endmodule

// File: rtl/jtag_master.sv
// JTAG initiator: turns RESET / IDLE / IR_SCAN / DR_SCAN commands into TMS/TDI
// sequences and keeps a mirror of the target TAP state.
// Ports:
//   TCK, TRST            - clock, synchronous active-high reset
//   cmd_valid/cmd_ready  - command handshake; cmd_op, cmd_len, cmd_data latched at accept
//   rsp_valid, rsp_data  - one-cycle pulse at the end of each scan, captured TDO bits
//   TMS, TDI, TDO        - JTAG pins (TMS/TDI registered)
//   state_obs            - mirrored TAP state
// Build option: define JTAG_MASTER_TDO_CAPTURE_EN to build the TDO capture
// register; without it rsp_data is tied to 0 and TDO is ignored.
module jtag_master
  import jtag_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 6
) (
  input  logic              TCK,
  input  logic              TRST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO,
  output logic [3:0]        state_obs
);

  localparam int unsigned CNT_W = LEN_W + 1;

  seq_state_t        seq_q;
  tap_state_t        tap_q, tap_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic [PRE_W-1:0]  pre_q, pre_bits;
  logic [2:0]        pre_n;
  logic [LEN_W-1:0]  len_q, len_clamp;
  logic [DATA_W-1:0] data_q;
  logic              tms_q, tdi_q, ready_q, rsp_valid_q;
  logic              accept, at_tlr, len_zero, scan_done;
  logic [CNT_W-1:0]  idle_cycles;

  jtag_tap_next u_tap_next (
    .state      (tap_q),
    .tms        (tms_q),
    .next_state (tap_nxt)
  );

  assign accept      = cmd_valid && ready_q;
  assign at_tlr      = (tap_q == TLR);
  assign len_clamp   = (cmd_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : cmd_len;
  assign len_zero    = (len_clamp == '0);
  assign idle_cycles = CNT_W'(len_clamp) + CNT_W'(at_tlr);
  assign scan_done   = (seq_q == S_POST) && (cnt_q == '0);

  // TMS prefix for a scan; a zero-length scan turns the final Capture->Shift
  // step into Capture->Exit1, and a TLR start prepends one TMS=0 step.
  always_comb begin
    pre_bits = '0;
    pre_n    = 3'd0;
    if (cmd_op_t'(cmd_op) == OP_IR_SCAN) begin
      pre_bits = PRE_W'(IR_PRE_TMS | {len_zero, 3'b000});
      pre_n    = 3'd4;
    end else begin
      pre_bits = PRE_W'(DR_PRE_TMS | {len_zero, 2'b00});
      pre_n    = 3'd3;
    end
    if (at_tlr) begin
      pre_bits = {pre_bits[PRE_W-2:0], 1'b0};
      pre_n    = pre_n + 3'd1;
    end
  end

  // Sequencer and mirror; TMS/TDI hold the value driven during the next cycle.
  always_ff @(posedge TCK) begin
    if (TRST) begin
      seq_q       <= S_IDLE;
      tap_q       <= TLR;
      cnt_q       <= '0;
      pre_q       <= '0;
      len_q       <= '0;
      data_q      <= '0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      tap_q       <= tap_nxt;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (seq_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            len_q  <= len_clamp;
            data_q <= cmd_data;
            case (cmd_op_t'(cmd_op))
              OP_RESET: begin
                tms_q   <= 1'b1;
                cnt_q   <= CNT_W'(RESET_TMS_CYCLES - 1);
                seq_q   <= S_RST_SEQ;
                ready_q <= 1'b0;
              end
              OP_IDLE: begin
                // Zero cycles from RTI is a no-op: stay ready.
                if (idle_cycles != '0) begin
                  tms_q   <= 1'b0;
                  cnt_q   <= idle_cycles - CNT_W'(1);
                  seq_q   <= S_PARK;
                  ready_q <= 1'b0;
                end
              end
              default: begin
                tms_q   <= pre_bits[0];
                pre_q   <= pre_bits >> 1;
                cnt_q   <= CNT_W'(pre_n) - CNT_W'(1);
                seq_q   <= S_PRE;
                ready_q <= 1'b0;
              end
            endcase
          end
        end
        S_RST_SEQ: begin
          tms_q <= 1'b1;
          if (cnt_q == '0) begin
            seq_q   <= S_IDLE;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_PARK: begin
          tms_q <= 1'b0;
          if (cnt_q == '0) begin
            seq_q   <= S_IDLE;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_PRE: begin
          if (cnt_q != '0) begin
            tms_q <= pre_q[0];
            pre_q <= pre_q >> 1;
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (len_q == '0) begin
            // Already in Exit1: go to Update.
            tms_q <= 1'b1;
            cnt_q <= CNT_W'(1);
            seq_q <= S_POST;
          end else begin
            tms_q  <= (len_q == LEN_W'(1));
            tdi_q  <= data_q[0];
            data_q <= data_q >> 1;
            cnt_q  <= CNT_W'(len_q) - CNT_W'(1);
            seq_q  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // cnt_q counts bits still to be driven after the current one.
          if (cnt_q == '0) begin
            tms_q <= 1'b1;
            cnt_q <= CNT_W'(1);
            seq_q <= S_POST;
          end else begin
            tms_q  <= (cnt_q == CNT_W'(1));
            tdi_q  <= data_q[0];
            data_q <= data_q >> 1;
            cnt_q  <= cnt_q - CNT_W'(1);
          end
        end
        S_POST: begin
          tms_q <= 1'b0;
          if (cnt_q != '0) begin
            cnt_q <= '0;
          end else begin
            seq_q       <= S_IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b1;
          end
        end
        default: begin
          seq_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef JTAG_MASTER_TDO_CAPTURE_EN
  logic [DATA_W-1:0] cap_q, rsp_data_q;

  // TDO enters at the MSB each shift edge; right-align by the scan length at the end.
  always_ff @(posedge TCK) begin
    if (TRST) begin
      cap_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      if (accept) begin
        cap_q <= '0;
      end else if (seq_q == S_SHIFT) begin
        cap_q <= {TDO, cap_q[DATA_W-1:1]};
      end
      if (scan_done) begin
        rsp_data_q <= cap_q >> (CNT_W'(DATA_W) - CNT_W'(len_q));
      end
    end
  end

  assign rsp_data = rsp_data_q;
`else
  logic unused_tdo;
  logic unused_scan_done;
  assign unused_tdo       = TDO;
  assign unused_scan_done = scan_done;
  assign rsp_data         = '0;
`endif

  assign cmd_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;
  assign state_obs = tap_q;

endmodule

// File: tb/tb_jtag_master.sv
// Directed bench for jtag_master; TDO loops back TDI (optionally inverted).
module tb_jtag_master;

`ifdef JTAG_MASTER_TDO_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic        TCK = 1'b0;
  logic        TRST;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        TMS, TDI, TDO;
  logic [3:0]  state_obs;
  logic        tdo_inv;

  int tot = 0;
  int bad = 0;

  always #5 TCK = ~TCK;
  assign TDO = TDI ^ tdo_inv;

  jtag_master #(.DATA_W(32), .LEN_W(6)) dut (
    .TCK       (TCK),
    .TRST      (TRST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .TMS       (TMS),
    .TDI       (TDI),
    .TDO       (TDO),
    .state_obs (state_obs)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tot++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge TCK);
    #1;
  endtask

  // Present a command, let it be accepted, then scramble the inputs.
  task automatic issue(input string tag, input logic [1:0] op, input logic [5:0] len,
                       input logic [31:0] data);
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    cmd_valid = 1'b1;
    check({tag, " rdy_at_accept"}, 64'(cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0;
    cmd_data  = ~data;
    cmd_len   = ~len;
  endtask

  // Follow n cycles after accept; trace nibble k-1 is the state after edge k.
  task automatic follow(input string tag, input int n, input logic [63:0] trace,
                        input logic [31:0] data, input logic rv, input logic [31:0] rsp);
    logic [63:0] tr;
    logic [31:0] d;
    logic [3:0]  es;
    logic        etdi;
    tr = trace;
    d  = data;
    es = 4'h0;
    for (int k = 1; k <= n; k++) begin
      step();
      es = tr[4*(k-1) +: 4];
      etdi = 1'b0;
      if (es == 4'h4 || es == 4'hB) begin
        etdi = d[0];
        d = d >> 1;
      end
      check($sformatf("%s state c%0d", tag, k), 64'(state_obs), 64'(es));
      check($sformatf("%s tdi c%0d", tag, k), 64'(TDI), 64'(etdi));
      check($sformatf("%s rdy c%0d", tag, k), 64'(cmd_ready), 64'(k == n));
      check($sformatf("%s rv c%0d", tag, k), 64'(rsp_valid), 64'(rv && (k == n)));
    end
    check({tag, " tms_hold"}, 64'(TMS), 64'(es == 4'h0));
    if (rv) check({tag, " rsp"}, 64'(rsp_data), CAP ? 64'(rsp) : 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [31:0] r;
    TRST = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = 6'd0; cmd_data = 32'd0;
    tdo_inv = 1'b0;

    // Reset values
    step(); step();
    check("rst tms", 64'(TMS), 64'd1);
    check("rst tdi", 64'(TDI), 64'd0);
    check("rst state", 64'(state_obs), 64'd0);
    check("rst rdy", 64'(cmd_ready), 64'd0);
    check("rst rv", 64'(rsp_valid), 64'd0);
    check("rst rsp", 64'(rsp_data), 64'd0);
    TRST = 1'b0;
    step();
    check("rdy after rst", 64'(cmd_ready), 64'd1);

    // IR scan from TLR, inverted TDO: bits 1,1,0,0 return as 0,0,1,1
    tdo_inv = 1'b1;
    issue("ir4", 2'd2, 6'd4, 32'h3);
    follow("ir4", 11, 64'h1FCBBBBA921, 32'h3, 1'b1, 32'hC);
    tdo_inv = 1'b0;

    // DR scan from RTI, loopback
    issue("dr8", 2'd3, 6'd8, 32'hA5);
    follow("dr8", 13, 64'h1854444444432, 32'hA5, 1'b1, 32'hA5);

    // Zero-length DR scan skips Shift
    issue("dr0", 2'd3, 6'd0, 32'hFFFF_FFFF);
    follow("dr0", 5, 64'h18532, 32'h0, 1'b1, 32'h0);

    // IDLE 3 with the next DR command offered early (ignored until ready)
    issue("idle3", 2'd1, 6'd3, 32'h0);
    cmd_op = 2'd3; cmd_len = 6'd1; cmd_data = 32'h1; cmd_valid = 1'b1;
    follow("idle3", 3, 64'h111, 32'h0, 1'b0, 32'h0);
    issue("dr1", 2'd3, 6'd1, 32'h1);
    follow("dr1", 6, 64'h185432, 32'h1, 1'b1, 32'h1);

    // Length 63 clamps to 32 bits
    issue("clamp", 2'd3, 6'd63, 32'hDEAD_BEEF);
    c = 0; r = 32'h0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (rsp_valid === 1'b1 && c == 0) begin
        c = k;
        r = rsp_data;
      end
    end
    check("clamp cycles", 64'(c), 64'd37);
    check("clamp rsp", 64'(r), CAP ? 64'hDEAD_BEEF : 64'd0);
    check("clamp state", 64'(state_obs), 64'd1);

    // RESET command from RTI
    issue("rst_rti", 2'd0, 6'd0, 32'h0);
    follow("rst_rti", 5, 64'h00092, 32'h0, 1'b0, 32'h0);

    // TRST in cycle 6 of a 32-bit DR scan
    issue("abort", 2'd3, 6'd32, 32'h1234_5678);
    for (int k = 1; k <= 5; k++) step();
    TRST = 1'b1;
    step();
    check("abort tms", 64'(TMS), 64'd1);
    check("abort state", 64'(state_obs), 64'd0);
    check("abort rdy", 64'(cmd_ready), 64'd0);
    check("abort rv", 64'(rsp_valid), 64'd0);
    check("abort tdi", 64'(TDI), 64'd0);
    check("abort rsp", 64'(rsp_data), 64'd0);
    TRST = 1'b0;
    step();
    check("abort rdy_back", 64'(cmd_ready), 64'd1);
    c = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (rsp_valid === 1'b1) c++;
    end
    check("abort no_rsp", 64'(c), 64'd0);
    check("abort idle_state", 64'(state_obs), 64'd0);
    issue("rst_tlr", 2'd0, 6'd0, 32'h0);
    follow("rst_tlr", 5, 64'h00000, 32'h0, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
